// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decode plus an iterative multiply/divide unit with HI/LO.
// The MDU stalls the pipeline for MDU ops while it iterates.
module alu_mdu_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [1:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [3:0]       alucontrol_o,
    output logic             jr_o,
    output logic             sign_o,
    output logic [1:0]       result_sel_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    // state | meaning
    // IDLE  | ready; accepts MDU issue and MTHI/MTLO
    // MUL   | shift-add, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // FIX   | sign correction, HI/LO written on exit
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_JR    = 6'd8;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_res_q, neg_rem_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic is_r, op_mult, op_div, op_mt, is_mdu, issue, signed_op, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;

    always_comb begin
        alucontrol_o = 4'b0010;
        case (alu_op_i)
            2'b00: alucontrol_o = 4'b0010;
            2'b01: alucontrol_o = 4'b0110;
            2'b11: alucontrol_o = 4'b0000;
            default: begin
                case (funct_i)
                    F_ADD:   alucontrol_o = 4'b0010;
                    F_SUB:   alucontrol_o = 4'b0110;
                    F_AND:   alucontrol_o = 4'b0000;
                    F_NOR:   alucontrol_o = 4'b1100;
                    F_SLT:   alucontrol_o = 4'b0111;
                    F_SLL:   alucontrol_o = 4'b0011;
                    default: alucontrol_o = 4'b0010;
                endcase
            end
        endcase
    end

    assign is_r    = (alu_op_i == 2'b10);
    assign jr_o    = is_r && (funct_i == F_JR);
    assign sign_o  = (alu_op_i != 2'b11);
    assign op_mult = is_r && (funct_i == F_MULT || funct_i == F_MULTU);
    assign op_div  = is_r && (funct_i == F_DIV || funct_i == F_DIVU);
    assign op_mt   = is_r && (funct_i == F_MTHI || funct_i == F_MTLO);
    assign is_mdu  = op_mult || op_div || op_mt ||
                     (is_r && (funct_i == F_MFHI || funct_i == F_MFLO));

    always_comb begin
        result_sel_o = 2'b00;
        if (is_r && funct_i == F_MFHI) result_sel_o = 2'b01;
        else if (is_r && funct_i == F_MFLO) result_sel_o = 2'b10;
    end

    assign stall_o   = valid_i && busy_o && is_mdu;
    assign issue     = (state_q == S_IDLE) && valid_i && !stall_o && (op_mult || op_div);
    // MULT and DIV have an even funct; the unsigned forms are odd.
    assign signed_op = !funct_i[0];
    assign a_neg     = signed_op && a_i[WIDTH-1];
    assign b_neg     = signed_op && b_i[WIDTH-1];
    assign abs_a     = a_neg ? -a_i : a_i;
    assign abs_b     = b_neg ? -b_i : b_i;
    assign b_zero    = (b_i == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = op_mult ? S_MUL : (b_zero ? S_FIX : S_DIV);
            S_MUL:  if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_DIV:  if (cnt_q == CNT_LAST) state_d = S_FIX;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
    end

    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        // Borrow out of the trial subtract means the divisor did not fit: restore.
        if (div_trial[WIDTH]) div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else                  div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    logic is_div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        cnt_q     <= '0;
                        mcand_q   <= abs_b;
                        // Divide by zero preloads remainder=|a| so FIX restores a's sign.
                        acc_q     <= (op_div && b_zero) ? {abs_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dz_q      <= op_div && b_zero;
                        is_div_q  <= op_div;
                    end else if (valid_i && op_mt) begin
                        if (funct_i == F_MTHI) hi_q <= a_i;
                        else                   lo_q <= a_i;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode table, MDU results via a scoreboard,
// stall behaviour, MTHI/MTLO and asynchronous reset abort.
module tb_alu_mdu_control;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic [3:0]    alucontrol;
    logic          jr, sign_w, stall, busy;
    logic [1:0]    result_sel;
    logic [W-1:0]  hi, lo;

    alu_mdu_control #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .valid_i(valid), .alu_op_i(alu_op), .funct_i(funct),
        .a_i(a), .b_i(b), .alucontrol_o(alucontrol), .jr_o(jr), .sign_o(sign_w),
        .result_sel_o(result_sel), .stall_o(stall), .busy_o(busy), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        valid = v; alu_op = op; funct = f; a = av; b = bv;
    endtask

    // Reference arithmetic in wide signed integers, independent of the iterative hardware.
    task automatic model(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint p;
        int     sa, sbv;
        sa = av; sbv = bv;
        eh = '0; el = '0;
        case (f)
            6'd24: begin p = longint'(sa) * longint'(sbv); {eh, el} = p; end
            6'd25: begin p = longint'({32'd0, av}) * longint'({32'd0, bv}); {eh, el} = p; end
            6'd26: begin
                if (sbv == 0) begin eh = av; el = '1; end
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin eh = '0; el = av; end
                else begin el = sa / sbv; eh = sa % sbv; end
            end
            default: begin
                if (bv == '0) begin eh = av; el = '1; end
                else begin el = av / bv; eh = av % bv; end
            end
        endcase
    endtask

    // Present one MDU op for a single cycle, then follow busy until it falls.
    task automatic run_mdu(input string tag, input logic [5:0] f, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [W-1:0] eh,
                           input logic [W-1:0] el, input int exp_busy);
        exp_t e;
        int   n;
        e.tag = tag; e.hi = eh; e.lo = el;
        sb.push_back(e);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, f, av, bv);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 6'd32, '0, '0);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(n), 64'(exp_busy));
        e = sb.pop_front();
        check({e.tag, " hi"}, 64'(hi), 64'(e.hi));
        check({e.tag, " lo"}, 64'(lo), 64'(e.lo));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [5:0] exp;   // {alucontrol, jr, sign}
    } dec_t;

    initial begin
        dec_t         dtab[$];
        logic [5:0]   rf[4];
        logic [W-1:0] ra, rb, eh, el;
        int           n, rs_err;

        reset = 1'b1;
        drive(1'b1, 2'b10, 6'd18, '0, '0);
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk); reset = 1'b0;

        dtab = '{
            '{2'b10, 6'd36, {4'b0000, 1'b0, 1'b1}}, '{2'b10, 6'd8,  {4'b0010, 1'b1, 1'b1}},
            '{2'b10, 6'd63, {4'b0010, 1'b0, 1'b1}}, '{2'b11, 6'd8,  {4'b0000, 1'b0, 1'b0}},
            '{2'b00, 6'd36, {4'b0010, 1'b0, 1'b1}}, '{2'b01, 6'd0,  {4'b0110, 1'b0, 1'b1}},
            '{2'b10, 6'd34, {4'b0110, 1'b0, 1'b1}}, '{2'b10, 6'd39, {4'b1100, 1'b0, 1'b1}},
            '{2'b10, 6'd42, {4'b0111, 1'b0, 1'b1}}, '{2'b10, 6'd0,  {4'b0011, 1'b0, 1'b1}},
            '{2'b10, 6'd32, {4'b0010, 1'b0, 1'b1}}, '{2'b10, 6'd24, {4'b0010, 1'b0, 1'b1}}
        };
        foreach (dtab[i]) begin
            drive(1'b0, dtab[i].op, dtab[i].f, '0, '0);
            #1;
            check($sformatf("decode op%0b f%0d", dtab[i].op, dtab[i].f),
                  64'({alucontrol, jr, sign_w}), 64'(dtab[i].exp));
        end
        drive(1'b0, 2'b10, 6'd16, '0, '0); #1;
        check("sel MFHI", 64'(result_sel), 64'd1);
        drive(1'b0, 2'b10, 6'd18, '0, '0); #1;
        check("sel MFLO", 64'(result_sel), 64'd2);
        drive(1'b0, 2'b00, 6'd18, '0, '0); #1;
        check("sel non-R", 64'(result_sel), 64'd0);
        drive(1'b0, 2'b10, 6'd32, '0, '0);

        run_mdu("MULTU", 6'd25, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 33);
        run_mdu("MULT", 6'd24, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        run_mdu("DIV", 6'd26, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_mdu("DIVU", 6'd27, 32'h7, 32'h2, 32'h1, 32'h3, 33);
        run_mdu("DIVU by 0", 6'd27, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1);
        run_mdu("DIV by 0", 6'd26, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
        run_mdu("DIV ovf", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);

        // MFLO held behind a MULT stalls until the result lands.
        sb.push_back('{"MULT+MFLO", 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd24, 32'hFFFF_FFFD, 32'h5);
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd18, '0, '0);
        n = 0; rs_err = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 200) begin
            n++;
            if (result_sel !== 2'b10) rs_err++;
            @(negedge clk);
        end
        check("MFLO stall cycles", 64'(n), 64'd33);
        check("MFLO sel while stalled", 64'(rs_err), 64'd0);
        begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, " lo at release"}, 64'(lo), 64'(e.lo));
            check({e.tag, " hi at release"}, 64'(hi), 64'(e.hi));
        end
        check("MFLO sel at release", 64'(result_sel), 64'd2);

        // Non-MDU instruction in the MDU shadow must not stall.
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd25, 32'h3, 32'h3);
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd32, 32'h1, 32'h1);
        @(negedge clk);
        check("shadow busy", 64'(busy), 64'd1);
        check("shadow ADD stall", 64'(stall), 64'd0);
        check("shadow ADD sel", 64'(result_sel), 64'd0);
        drive(1'b0, 2'b10, 6'd32, '0, '0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        check("shadow MULTU lo", 64'(lo), 64'd9);

        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd17, 32'h1234, '0);
        @(negedge clk);
        check("MTHI before edge", 64'(hi), 64'd0);
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd19, 32'h5678, '0);
        check("MTHI hi", 64'(hi), 64'h1234);
        @(posedge clk); #1; drive(1'b0, 2'b10, 6'd32, '0, '0);
        check("MTLO lo", 64'(lo), 64'h5678);

        rf = '{6'd24, 6'd25, 6'd26, 6'd27};
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k == 5) ? '0 : ((k % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            model(rf[k % 4], ra, rb, eh, el);
            run_mdu($sformatf("rand%0d f%0d", k, rf[k % 4]), rf[k % 4], ra, rb, eh, el,
                    (rf[k % 4][1] && rb == '0) ? 1 : 33);
        end

        // Reset in the middle of a MULT clears everything without a clock edge.
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd24, 32'h1111, 32'h2222);
        @(posedge clk); #1; drive(1'b1, 2'b10, 6'd18, '0, '0);
        repeat (10) @(negedge clk);
        check("pre-reset stall", 64'(stall), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset stall", 64'(stall), 64'd0);
        check("async reset hi", 64'(hi), 64'd0);
        check("async reset lo", 64'(lo), 64'd0);
        @(negedge clk); reset = 1'b0;
        drive(1'b0, 2'b10, 6'd32, '0, '0);
        repeat (40) @(negedge clk);
        check("aborted no write hi", 64'(hi), 64'd0);
        check("aborted no write lo", 64'(lo), 64'd0);
        run_mdu("MULT 6*7", 6'd24, 32'd6, 32'd7, 32'd0, 32'd42, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
